rf_seq_ctrl: RTL and testbench
==============================

# rf_seq_ctrl

Command front-end that sits directly upstream of the 8-entry x 4-bit register file (`reg_file`), driving its `we`/`addr`/`wdata` port and consuming its `rdata`. It accepts single write, single read, block fill and block dump commands over a valid/ready handshake. It serializes them into register-file accesses and returns read data over a valid/ready response channel. It replaces hand-sequenced bench loops with a reusable hardware sequencer.

## Interface
- `AW`, 3, register-file address width
- `DW`, 4, register-file data width
- `DEPTH`, 8, number of entries; must equal 2**AW

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  2  00 write, 01 read, 10 fill, 11 dump
- `cmd_addr`  in  AW  target entry (write/read); ignored for fill/dump
- `cmd_data`  in  DW  write data (write); base value (fill); ignored otherwise
- `rsp_valid`  out  1  read response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_addr`  out  AW  entry the response came from
- `rsp_data`  out  DW  entry contents
- `busy`  out  1  high whenever state is not IDLE
- `rf_we`  out  1  to reg_file `we`
- `rf_addr`  out  AW  to reg_file `addr`
- `rf_wdata`  out  DW  to reg_file `wdata`
- `rf_rdata`  in  DW  from reg_file `rdata`

## Operation
- States: IDLE, WR, RD_ADDR, RD_CAP, RSP, FILL, DMP_ADDR, DMP_CAP, DMP_RSP.
- `cmd_ready` = (state==IDLE) && !rst. A command is accepted on an edge with `cmd_valid && cmd_ready`. `cmd_op/addr/data` are latched at acceptance. `cmd_valid` outside IDLE is ignored; the command is neither queued nor dropped silently, and the source must hold it.
- Write: IDLE -> WR. WR lasts one cycle with `rf_we`=1, `rf_addr`=addr, `rf_wdata`=data. WR -> IDLE.
- Read: IDLE -> RD_ADDR -> RD_CAP -> RSP. `rf_addr`=addr and `rf_we`=0 are held through RD_ADDR and RD_CAP. `rf_rdata` is sampled into `rsp_data` on the edge leaving RD_CAP. This works for both combinational and one-cycle registered reg_file reads. In RSP, `rsp_valid`=1, and the state returns to IDLE on the edge with `rsp_ready`=1.
- Fill: IDLE -> FILL. The internal index `i` counts 0..DEPTH-1, one entry per cycle. `rf_we`=1, `rf_addr`=i, `rf_wdata`=(base+i) mod 2**DW (truncating add). The state returns to IDLE after i=DEPTH-1.
- Dump: for i=0..DEPTH-1, DMP_ADDR -> DMP_CAP -> DMP_RSP. The address, capture and backpressure behaviour matches Read, with `rsp_addr`=i. After entry DEPTH-1 is accepted, the state returns to IDLE; otherwise i increments and the sequence goes back to DMP_ADDR.
- `rf_we` is 0 in every state except WR and FILL.
- `rf_addr` and `rf_wdata` are 0 in IDLE.
- Response stability: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_addr` and `rsp_data` are held constant. A response is never skipped or duplicated.

## Timing
- Reset: on an edge with `rst`=1, the state goes to IDLE and i=0. In the following cycle, `rf_we`=0, `rf_addr`=0, `rf_wdata`=0, `rsp_valid`=0, `rsp_addr`=0, `rsp_data`=0 and `busy`=0. `cmd_ready`=0 while `rst` is high.
- Reset mid-operation aborts immediately. Fill entries already written stay written; no further writes are issued. A pending response is discarded.
- Write: accept at edge E0. `rf_we`=1 during the cycle E0..E1, and the reg_file updates at E1. `cmd_ready`=1 again after E1. Throughput is 1 write per 2 cycles.
- Read: accept at E0. `rsp_valid` rises after E2 with `rsp_ready` held high, and `cmd_ready` returns after E3. The minimum is 4 cycles per read.
- Fill: accept at E0. Writes occur at edges E1..E8, and `cmd_ready` returns after E8.
- Dump: 3 cycles per entry with no backpressure, giving 24 cycles plus 1 cycle to return to IDLE.
- No combinational path from `rsp_ready` or `cmd_valid` to any `rf_*` output.

## Test plan
- Fill with base=0, then dump -> `rf_we` high for exactly 8 consecutive cycles with addr 0..7; 8 responses (addr i, data i) in order, `busy` low after the last.
- Write addr=5 data=0xA, then read addr=5 -> one response with `rsp_addr`=5, `rsp_data`=0xA; the other entries are unchanged.
- Fill with base=0xE -> dump returns E,F,0,1,2,3,4,5 for entries 0..7 (wrap-around).
- Dump with `rsp_ready` low for 3 cycles while entry 2 is presented -> `rsp_valid` stays high, and `rsp_addr`=2 and `rsp_data` stay stable. Entries continue from 3 with none lost or repeated.
- Fill base=0x8 over an all-0x3 file; assert `rst` after the 3rd write -> all outputs reach reset values the next cycle. A subsequent dump returns 8,9,A,3,3,3,3,3.
- Hold `cmd_valid` with a write during an active dump -> `cmd_ready`=0 throughout; the write is accepted on the first IDLE edge, and the dump data is unaffected.

Source files
------------

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: command sequencer in front of an 8 x 4 register file.
// Accepts write / read / fill / dump commands on a valid/ready channel. It
// turns them into reg_file accesses and returns read data on a valid/ready
// response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake
//   cmd_op                   00 write, 01 read, 10 fill, 11 dump
//   cmd_addr/data            command address / write data or fill base
//   rsp_valid/ready          response handshake
//   rsp_addr/data            responding entry and its contents
//   busy                     controller not idle
//   rf_we/addr/wdata/rdata   register-file access port
module rf_seq_ctrl #(
    parameter int AW    = 3,
    parameter int DW    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_CAP,
        S_RSP,
        S_FILL,
        S_DMP_ADDR,
        S_DMP_CAP,
        S_DMP_RSP
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic [AW-1:0] rsp_addr_q;
    logic [DW-1:0] rsp_data_q;
    logic          accept;
    logic          last;
    logic          capture;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (idx == AW'(DEPTH - 1));
    assign busy      = (state != S_IDLE);
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // rf_* are decoded from state/idx/latched command only, so neither
    // cmd_valid nor rsp_ready reaches them combinationally.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        rsp_valid = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    idx_nxt = '0;
                    case (cmd_op)
                        2'b00:   state_nxt = S_WR;
                        2'b01:   state_nxt = S_RD_ADDR;
                        2'b10:   state_nxt = S_FILL;
                        default: state_nxt = S_DMP_ADDR;
                    endcase
                end
            end
            S_WR: begin
                rf_we     = 1'b1;
                rf_addr   = lat_addr;
                rf_wdata  = lat_data;
                state_nxt = S_IDLE;
            end
            S_RD_ADDR: begin
                rf_addr   = lat_addr;
                state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                // Address has been stable a full cycle, so both combinational
                // and registered reg_file reads are valid here.
                rf_addr   = lat_addr;
                capture   = 1'b1;
                state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            S_FILL: begin
                rf_we    = 1'b1;
                rf_addr  = idx;
                rf_wdata = lat_data + DW'(idx);
                if (last) begin
                    idx_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_DMP_ADDR: begin
                rf_addr   = idx;
                state_nxt = S_DMP_CAP;
            end
            S_DMP_CAP: begin
                rf_addr   = idx;
                capture   = 1'b1;
                state_nxt = S_DMP_RSP;
            end
            S_DMP_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (last) begin
                        idx_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_DMP_ADDR;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Response registers only load on capture, which keeps them stable
    // across any amount of backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr   <= '0;
            lat_data   <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                lat_addr <= cmd_addr;
                lat_data <= cmd_data;
            end
            if (capture) begin
                rsp_addr_q <= rf_addr;
                rsp_data_q <= rf_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: directed self-checking bench for rf_seq_ctrl with a
// behavioural 8 x 4 register file (combinational read) attached.
module tb_rf_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_addr;
    logic [3:0] rsp_data;
    logic       busy;
    logic       rf_we;
    logic [2:0] rf_addr;
    logic [3:0] rf_wdata;
    logic [3:0] rf_rdata;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [8];
    logic [2:0] got_a [16];
    logic [3:0] got_d [16];
    logic [2:0] we_a  [16];
    logic [3:0] we_d  [16];
    int         n_rsp;
    int         n_we;

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_wdata;
    assign rf_rdata = mem[rf_addr];

    rf_seq_ctrl #(.AW(3), .DW(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    // Presents a command and returns at the negedge just after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] a,
                            input logic [3:0] d, output bit ok);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Records writes and handshaken responses until the controller idles.
    task automatic watch(input int max_cycles, output bit timeout);
        n_rsp = 0; n_we = 0; timeout = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            if (rf_we && n_we < 16) begin
                we_a[n_we] = rf_addr; we_d[n_we] = rf_wdata; n_we++;
            end
            if (rsp_valid && rsp_ready && n_rsp < 16) begin
                got_a[n_rsp] = rsp_addr; got_d[n_rsp] = rsp_data; n_rsp++;
            end
            if (!busy) begin timeout = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [17:0] v;
        v = {rf_we, rf_addr, rf_wdata, rsp_valid, rsp_addr, rsp_data, busy, cmd_ready};
        checks++;
        if (v !== 18'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", v, 18'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_release: got %b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_fill_dump;
        bit ok, to;
        send_cmd(2'b10, 3'd0, 4'h0, ok);
        watch(40, to);
        checks++;
        if (!ok || to || n_we != 8) begin
            errors++; $display("FAIL fill0_count: got ok=%0b to=%0b n_we=%0d expected 1 0 8", ok, to, n_we);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (we_a[i] !== 3'(i) || we_d[i] !== 4'(i)) begin
                errors++; $display("FAIL fill0_write%0d: got a=%h d=%h expected a=%h d=%h", i, we_a[i], we_d[i], 3'(i), 4'(i));
            end
        end
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        watch(60, to);
        checks++;
        if (!ok || to || n_rsp != 8 || n_we != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL dump0_count: got ok=%0b to=%0b n_rsp=%0d n_we=%0d busy=%b expected 1 0 8 0 0", ok, to, n_rsp, n_we, busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_a[i] !== 3'(i) || got_d[i] !== 4'(i)) begin
                errors++; $display("FAIL dump0_rsp%0d: got a=%h d=%h expected a=%h d=%h", i, got_a[i], got_d[i], 3'(i), 4'(i));
            end
        end
    endtask

    task automatic test_write_read;
        bit ok, to;
        logic [3:0] exp [8];
        exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'h6, 4'h7};
        send_cmd(2'b00, 3'd5, 4'hA, ok);
        checks++;
        if (!ok || {rf_we, rf_addr, rf_wdata} !== {1'b1, 3'd5, 4'hA}) begin
            errors++; $display("FAIL write_cycle: got ok=%0b we=%b a=%h d=%h expected 1 1 5 a", ok, rf_we, rf_addr, rf_wdata);
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, rf_we} !== 2'b10) begin
            errors++; $display("FAIL write_done: got %b expected 10", {cmd_ready, rf_we});
        end
        send_cmd(2'b01, 3'd5, 4'h0, ok);
        checks++;
        if (!ok || {rsp_valid, rf_we, rf_addr} !== {1'b0, 1'b0, 3'd5}) begin
            errors++; $display("FAIL read_addr: got ok=%0b v=%b we=%b a=%h expected 1 0 0 5", ok, rsp_valid, rf_we, rf_addr);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rf_addr} !== {1'b0, 3'd5}) begin
            errors++; $display("FAIL read_cap: got v=%b a=%h expected 0 5", rsp_valid, rf_addr);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd5, 4'hA}) begin
            errors++; $display("FAIL read_rsp: got v=%b a=%h d=%h expected 1 5 a", rsp_valid, rsp_addr, rsp_data);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL read_done: got %b expected 01", {rsp_valid, cmd_ready});
        end
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        watch(60, to);
        checks++;
        if (!ok || to || n_rsp != 8) begin
            errors++; $display("FAIL wr_dump_count: got n_rsp=%0d to=%0b expected 8 0", n_rsp, to);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_d[i] !== exp[i]) begin
                errors++; $display("FAIL wr_dump%0d: got %h expected %h", i, got_d[i], exp[i]);
            end
        end
    endtask

    task automatic test_fill_wrap;
        bit ok, to;
        logic [3:0] exp [8];
        exp = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        send_cmd(2'b10, 3'd6, 4'hE, ok);
        watch(40, to);
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        watch(60, to);
        checks++;
        if (!ok || to || n_rsp != 8) begin
            errors++; $display("FAIL wrap_count: got n_rsp=%0d to=%0b expected 8 0", n_rsp, to);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_a[i] !== 3'(i) || got_d[i] !== exp[i]) begin
                errors++; $display("FAIL wrap_rsp%0d: got a=%h d=%h expected a=%h d=%h", i, got_a[i], got_d[i], 3'(i), exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok, stalled;
        logic [3:0] exp [8];
        exp = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        stalled = 1'b0; n_rsp = 0;
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        for (int k = 0; k < 80; k++) begin
            if (rsp_valid) begin
                if (rsp_addr == 3'd2 && !stalled) begin
                    stalled = 1'b1;
                    rsp_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        checks++;
                        if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 3'd2, 4'h0}) begin
                            errors++; $display("FAIL stall%0d: got v=%b a=%h d=%h expected 1 2 0", s, rsp_valid, rsp_addr, rsp_data);
                        end
                    end
                    rsp_ready = 1'b1;
                end
                if (n_rsp < 16) begin
                    got_a[n_rsp] = rsp_addr; got_d[n_rsp] = rsp_data; n_rsp++;
                end
            end
            if (!busy) break;
            @(negedge clk);
        end
        checks++;
        if (!ok || busy !== 1'b0 || n_rsp != 8) begin
            errors++; $display("FAIL bp_count: got ok=%0b busy=%b n_rsp=%0d expected 1 0 8", ok, busy, n_rsp);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_a[i] !== 3'(i) || got_d[i] !== exp[i]) begin
                errors++; $display("FAIL bp_rsp%0d: got a=%h d=%h expected a=%h d=%h", i, got_a[i], got_d[i], 3'(i), exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill;
        bit ok, to;
        int extra;
        logic [17:0] v;
        logic [3:0] exp [8];
        exp = '{4'h8, 4'h9, 4'hA, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
        for (int a = 0; a < 8; a++) send_cmd(2'b00, 3'(a), 4'h3, ok);
        send_cmd(2'b10, 3'd0, 4'h8, ok);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = {rf_we, rf_addr, rf_wdata, rsp_valid, rsp_addr, rsp_data, busy, cmd_ready};
        checks++;
        if (v !== 18'h0) begin
            errors++; $display("FAIL midrst_outputs: got %h expected %h", v, 18'h0);
        end
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            if (rf_we) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL midrst_nowrite: got %0d expected 0", extra);
        end
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        watch(60, to);
        checks++;
        if (!ok || to || n_rsp != 8) begin
            errors++; $display("FAIL midrst_count: got n_rsp=%0d to=%0b expected 8 0", n_rsp, to);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_d[i] !== exp[i]) begin
                errors++; $display("FAIL midrst_rsp%0d: got %h expected %h", i, got_d[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok, done;
        int bad_ready;
        logic [3:0] exp [8];
        exp = '{4'h8, 4'h9, 4'hA, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
        send_cmd(2'b11, 3'd0, 4'h0, ok);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'd1; cmd_data = 4'h7;
        n_rsp = 0; bad_ready = 0; done = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (!busy) begin done = 1'b1; break; end
            if (cmd_ready) bad_ready++;
            if (rsp_valid && n_rsp < 16) begin
                got_a[n_rsp] = rsp_addr; got_d[n_rsp] = rsp_data; n_rsp++;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || !done || bad_ready != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_hold: got ok=%0b done=%0b bad_ready=%0d rdy=%b expected 1 1 0 1", ok, done, bad_ready, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 3'd1, 4'h7}) begin
            errors++; $display("FAIL b2b_write: got we=%b a=%h d=%h expected 1 1 7", rf_we, rf_addr, rf_wdata);
        end
        checks++;
        if (n_rsp != 8) begin
            errors++; $display("FAIL b2b_count: got %0d expected 8", n_rsp);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_a[i] !== 3'(i) || got_d[i] !== exp[i]) begin
                errors++; $display("FAIL b2b_rsp%0d: got a=%h d=%h expected a=%h d=%h", i, got_a[i], got_d[i], 3'(i), exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (mem[1] !== 4'h7) begin
            errors++; $display("FAIL b2b_mem1: got %h expected 7", mem[1]);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
        cmd_data = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        test_fill_dump;
        test_write_read;
        test_fill_wrap;
        test_backpressure;
        test_reset_mid_fill;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
